id_ex_stage: RTL

ID/EX pipeline stage of the pipelined MIPS-Lite CPU; it sits directly upstream of the EX-stage ALU and drives it. It registers the decoded instruction from ID and produces the 3-bit ALU control from `aluop`/`funct`. It forwards operands from EX/MEM and MEM/WB and selects register or immediate for operand B. It also detects load-use hazards, inserting a bubble and requesting an ID/IF stall.

---
 rtl/id_ex_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, operand forwarding
// and load-use hazard detection for the MIPS-Lite pipeline.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc4,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_shamt,
    input  logic [5:0]  id_funct,
    input  logic [1:0]  id_aluop,
    input  logic        id_alusrc,
    input  logic        id_regdst,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        id_branch,
    input  logic        flush,
    input  logic        stall,
    input  logic        exm_regwrite,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        mwb_regwrite,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_data,
    output logic [2:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_wreg,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_imm,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        ex_branch,
    output logic        load_use_stall
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [1:0]  aluop;
        logic        alusrc;
        logic        regdst;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        branch;
    } id_ex_t;

    id_ex_t stage_q, stage_d, id_in;
    logic [31:0] fwd_rs, fwd_rt;

    always_comb begin
        id_in          = '0;
        id_in.valid    = id_valid;
        id_in.pc4      = id_pc4;
        id_in.rs_data  = id_rs_data;
        id_in.rt_data  = id_rt_data;
        id_in.imm      = id_imm;
        id_in.rs       = id_rs;
        id_in.rt       = id_rt;
        id_in.rd       = id_rd;
        id_in.shamt    = id_shamt;
        id_in.funct    = id_funct;
        id_in.aluop    = id_aluop;
        id_in.alusrc   = id_alusrc;
        id_in.regdst   = id_regdst;
        id_in.regwrite = id_regwrite;
        id_in.memread  = id_memread;
        id_in.memwrite = id_memwrite;
        id_in.memtoreg = id_memtoreg;
        id_in.branch   = id_branch;
    end

    // Gated by flush/stall, which outrank the load-use bubble anyway
    assign load_use_stall = stage_q.valid & stage_q.memread & id_valid
                          & (stage_q.rt != 5'd0)
                          & ((stage_q.rt == id_rs) | (stage_q.rt == id_rt))
                          & ~flush & ~stall;

    always_comb begin
        stage_d = id_in;
        if (flush)
            stage_d = '0;
        else if (stall)
            stage_d = stage_q;
        else if (load_use_stall)
            stage_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stage_q <= '0;
        else
            stage_q <= stage_d;
    end

    function automatic logic [31:0] fwd(
        input logic [4:0]  r,
        input logic [31:0] d,
        input logic        xw,
        input logic [4:0]  xr,
        input logic [31:0] xv,
        input logic        ww,
        input logic [4:0]  wr,
        input logic [31:0] wv
    );
        if (xw && xr != 5'd0 && xr == r)
            return xv;
        else if (ww && wr != 5'd0 && wr == r)
            return wv;
        else
            return d;
    endfunction

    always_comb begin
        fwd_rs = fwd(stage_q.rs, stage_q.rs_data,
                     exm_regwrite, exm_rd, exm_result,
                     mwb_regwrite, mwb_rd, mwb_data);
        fwd_rt = fwd(stage_q.rt, stage_q.rt_data,
                     exm_regwrite, exm_rd, exm_result,
                     mwb_regwrite, mwb_rd, mwb_data);
    end

    always_comb begin
        alu_ctl = 3'b010;
        case (stage_q.aluop)
            2'b01: alu_ctl = 3'b110;
            2'b10: begin
                case (stage_q.funct)
                    6'h20:   alu_ctl = 3'b010;
                    6'h22:   alu_ctl = 3'b110;
                    6'h24:   alu_ctl = 3'b000;
                    6'h25:   alu_ctl = 3'b001;
                    6'h2A:   alu_ctl = 3'b111;
                    6'h02:   alu_ctl = 3'b011;
                    default: alu_ctl = 3'b010;
                endcase
            end
            default: alu_ctl = 3'b010;
        endcase
    end

    assign alu_a         = fwd_rs;
    assign alu_b         = stage_q.alusrc ? stage_q.imm : fwd_rt;
    assign alu_shamt     = stage_q.shamt;
    assign ex_store_data = fwd_rt;
    assign ex_wreg       = stage_q.regdst ? stage_q.rd : stage_q.rt;
    assign ex_pc4        = stage_q.pc4;
    assign ex_imm        = stage_q.imm;
    assign ex_valid      = stage_q.valid;
    assign ex_regwrite   = stage_q.regwrite;
    assign ex_memread    = stage_q.memread;
    assign ex_memwrite   = stage_q.memwrite;
    assign ex_memtoreg   = stage_q.memtoreg;
    assign ex_branch     = stage_q.branch;

endmodule
